conv_dma_rd_arb: RTL

- Shares one MCIF read channel (request and response) between the convolution data DMA and weight DMA requesters.
- Arbitrates read-request commands round-robin and records the owner and burst length of each accepted command in an in-order tracking FIFO.
- Steers each response beat back to the owning requester.
- Sits between the dat/wt DMA engines and the single MCIF read port.

---
 rtl/conv_dma_rd_arb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/conv_dma_rd_arb.sv
// conv_dma_rd_arb: shares one MCIF read channel between the conv dat and wt DMAs (round-robin requests, in-order response steering).
// Define CONV_RD_ARB_WT_PRIO_EN to give wt strict priority whenever both requesters are valid.
module conv_dma_rd_arb #(
    parameter int LEN_W      = 4,
    parameter int REQ_PD_W   = LEN_W + 64,
    parameter int RESP_DW    = 256,
    parameter int MAX_OUTSTD = 8,
    parameter int OUTSTD_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dat_req_vld,
    output logic                dat_req_rdy,
    input  logic [REQ_PD_W-1:0] dat_req_pd,
    input  logic                wt_req_vld,
    output logic                wt_req_rdy,
    input  logic [REQ_PD_W-1:0] wt_req_pd,
    output logic                mcif_req_vld,
    input  logic                mcif_req_rdy,
    output logic [REQ_PD_W-1:0] mcif_req_pd,
    output logic                mcif_req_id,
    input  logic                mcif_resp_vld,
    output logic                mcif_resp_rdy,
    input  logic [RESP_DW-1:0]  mcif_resp_pd,
    output logic                dat_resp_vld,
    input  logic                dat_resp_rdy,
    output logic                wt_resp_vld,
    input  logic                wt_resp_rdy,
    output logic [RESP_DW-1:0]  resp_pd,
    output logic [OUTSTD_W-1:0] outstd_cnt,
    output logic                idle,
    output logic                err_unexp_resp
);

    localparam int PTR_W = $clog2(MAX_OUTSTD);
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [OUTSTD_W-1:0] CNT_FULL = OUTSTD_W'(MAX_OUTSTD);

    logic [0:0]          state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_grant_q, last_grant_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OUTSTD_W-1:0] outstd_cnt_q, outstd_cnt_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                err_q, err_d;

    logic                fifo_id_q  [MAX_OUTSTD];
    logic [LEN_W-1:0]    fifo_len_q [MAX_OUTSTD];

    logic                full;
    logic                pick;
    logic                req_vld;
    logic                accept;
    logic                fifo_empty;
    logic                head_id;
    logic [LEN_W-1:0]    head_len;
    logic                beat;
    logic                pop;

    // Request selection: HOLD pins the owner until MCIF takes the command.
    always_comb begin
        full    = (outstd_cnt_q == CNT_FULL);
        pick    = 1'b0;
        req_vld = 1'b0;
        if (state_q == HOLD) begin
            pick    = sel_q;
            req_vld = sel_q ? wt_req_vld : dat_req_vld;
        end else if (!full) begin
            req_vld = dat_req_vld | wt_req_vld;
            if (dat_req_vld & wt_req_vld) begin
`ifdef CONV_RD_ARB_WT_PRIO_EN
                pick = 1'b1;
`else
                pick = ~last_grant_q;
`endif
            end else begin
                pick = wt_req_vld;
            end
        end
    end

    // NOTE: handshake outputs are forced low while rst is high so nothing is exchanged in the reset cycle.
    assign mcif_req_vld = ~rst & req_vld;
    assign mcif_req_id  = pick;
    assign mcif_req_pd  = pick ? wt_req_pd : dat_req_pd;
    assign accept       = mcif_req_vld & mcif_req_rdy;
    assign dat_req_rdy  = accept & ~pick;
    assign wt_req_rdy   = accept & pick;

    assign fifo_empty    = (outstd_cnt_q == '0);
    assign head_id       = fifo_id_q[rd_ptr_q];
    assign head_len      = fifo_len_q[rd_ptr_q];
    assign dat_resp_vld  = ~rst & ~fifo_empty & mcif_resp_vld & ~head_id;
    assign wt_resp_vld   = ~rst & ~fifo_empty & mcif_resp_vld & head_id;
    assign mcif_resp_rdy = ~rst & ~fifo_empty & (head_id ? wt_resp_rdy : dat_resp_rdy);
    assign resp_pd       = mcif_resp_pd;
    assign beat          = mcif_resp_vld & mcif_resp_rdy;
    assign pop           = beat & (beat_cnt_q == head_len);

    assign outstd_cnt     = outstd_cnt_q;
    assign idle           = (outstd_cnt_q == '0) & ~dat_req_vld & ~wt_req_vld & (state_q == ARB);
    assign err_unexp_resp = err_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        outstd_cnt_d = outstd_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;

        case (state_q)
            ARB: begin
                if (req_vld & ~mcif_req_rdy) begin
                    state_d = HOLD;
                    sel_d   = pick;
                end
            end
            default: begin
                if (mcif_req_rdy) state_d = ARB;
            end
        endcase

        if (accept) begin
            last_grant_d = pick;
            wr_ptr_d     = wr_ptr_q + 1'b1;
        end

        if (beat) beat_cnt_d = pop ? '0 : beat_cnt_q + 1'b1;
        if (pop)  rd_ptr_d   = rd_ptr_q + 1'b1;

        case ({accept, pop})
            2'b10:   outstd_cnt_d = outstd_cnt_q + 1'b1;
            2'b01:   outstd_cnt_d = outstd_cnt_q - 1'b1;
            default: outstd_cnt_d = outstd_cnt_q;
        endcase

        if (fifo_empty & mcif_resp_vld) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            outstd_cnt_q <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            outstd_cnt_q <= outstd_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    // NOTE: tracking storage is not reset; outstd_cnt_q alone decides which entries are live, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_id_q[wr_ptr_q]  <= pick;
            fifo_len_q[wr_ptr_q] <= mcif_req_pd[REQ_PD_W-1 -: LEN_W];
        end
    end

endmodule
